// File: rtl/out_display.sv
// CPU output peripheral: latches an OUT value, converts it to BCD (double-dabble), drives 8 seven-segment digits and 18 LEDs.
// Optional two's-complement display with a leading minus sign when OUT_DISPLAY_SIGNED_EN is defined.
module out_display #(
  parameter int DATA_WIDTH     = 32,
  parameter int DIGITS         = 8,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  escreveOutput,
  input  logic [DATA_WIDTH-1:0] entrada,
  output logic                  haltOut,
  output logic [17:0]           leds,
  output logic [6:0]            hex0,
  output logic [6:0]            hex1,
  output logic [6:0]            hex2,
  output logic [6:0]            hex3,
  output logic [6:0]            hex4,
  output logic [6:0]            hex5,
  output logic [6:0]            hex6,
  output logic [6:0]            hex7
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [6:0] BLANK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] DASH  = 7'h40;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

`ifdef OUT_DISPLAY_SIGNED_EN
  localparam logic [63:0] LIMIT = pow10(DIGITS - 1) - 64'd1;
`else
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
`endif

  // Active-high glyphs, bit0 = a .. bit6 = g
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   bin_reg;
  logic [BW-1:0]           bcd_reg;
  logic [CW-1:0]           cnt_reg;
  logic                    ovf_reg;
  logic [17:0]             leds_reg;
  logic [7:0][6:0]         disp_reg;
  logic [7:0][6:0]         disp_next;
  logic [BW-1:0]           bcd_adj;
  logic [DATA_WIDTH-1:0]   mag;
  logic                    ovf_in;
  int                      msd;

`ifdef OUT_DISPLAY_SIGNED_EN
  logic neg_in, neg_reg;
  always_comb begin
    neg_in = entrada[DATA_WIDTH-1];
    mag    = neg_in ? -entrada : entrada;
    // The most negative value negates to itself, so its top bit stays set
    ovf_in = (neg_in && mag[DATA_WIDTH-1]) || (64'(mag) > LIMIT);
  end
`else
  always_comb begin
    mag    = entrada;
    ovf_in = 64'(entrada) > LIMIT;
  end
`endif

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_add3
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                              : bcd_reg[gi*4 +: 4];
  end

  always_comb begin
    msd = 0;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_reg[k*4 +: 4] != 4'd0) msd = k;
  end

  for (gi = 0; gi < 8; gi++) begin : g_digit
    if (gi < DIGITS) begin : g_used
      logic [6:0] seg;
      always_comb begin
        seg = 7'h00;
        if (ovf_reg) seg = DASH;
        else if (gi <= msd) seg = glyph(bcd_reg[gi*4 +: 4]);
`ifdef OUT_DISPLAY_SIGNED_EN
        else if (neg_reg && (gi == msd + 1)) seg = DASH;
`endif
      end
      assign disp_next[gi] = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
    end else begin : g_blank
      assign disp_next[gi] = BLANK;
    end
  end

  always_comb begin
    state_next = state_reg;
    haltOut    = 1'b0;
    case (state_reg)
      IDLE: begin
        haltOut = escreveOutput & ~reset;
        if (escreveOutput) state_next = ovf_in ? DONE : CONVERT;
      end
      CONVERT: begin
        haltOut = 1'b1;
        if (cnt_reg == CW'(DATA_WIDTH - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      leds_reg  <= '0;
      disp_reg  <= {8{BLANK}};
`ifdef OUT_DISPLAY_SIGNED_EN
      neg_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (escreveOutput) begin
          bin_reg  <= mag;
          leds_reg <= entrada[17:0];
          bcd_reg  <= '0;
          cnt_reg  <= '0;
          ovf_reg  <= ovf_in;
`ifdef OUT_DISPLAY_SIGNED_EN
          neg_reg  <= neg_in;
`endif
        end
        CONVERT: begin
          bcd_reg <= {bcd_adj[BW-2:0], bin_reg[DATA_WIDTH-1]};
          bin_reg <= {bin_reg[DATA_WIDTH-2:0], 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
        end
        DONE:    disp_reg <= disp_next;
        default: ;
      endcase
    end
  end

  assign leds = leds_reg;
  assign hex0 = disp_reg[0];
  assign hex1 = disp_reg[1];
  assign hex2 = disp_reg[2];
  assign hex3 = disp_reg[3];
  assign hex4 = disp_reg[4];
  assign hex5 = disp_reg[5];
  assign hex6 = disp_reg[6];
  assign hex7 = disp_reg[7];

endmodule

// File: tb/tb_out_display.sv
// Directed self-checking bench for out_display (default parameters, active-low segments).
// Signed-mode vectors are compiled in when OUT_DISPLAY_SIGNED_EN is defined.
module tb_out_display;

  logic        clock;
  logic        reset;
  logic        escreveOutput;
  logic [31:0] entrada;
  logic        haltOut;
  logic [17:0] leds;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [55:0] disp;

  int checks   = 0;
  int failures = 0;

  // Active-low glyphs
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DA = 7'h3F;
  localparam logic [6:0] D0 = 7'h40;
  localparam logic [6:0] D1 = 7'h79;
  localparam logic [6:0] D2 = 7'h24;
  localparam logic [6:0] D3 = 7'h30;
  localparam logic [6:0] D4 = 7'h19;
  localparam logic [6:0] D5 = 7'h12;
  localparam logic [6:0] D6 = 7'h02;
  localparam logic [6:0] D7 = 7'h78;
  localparam logic [6:0] D9 = 7'h10;

  out_display dut (
    .clock(clock), .reset(reset), .escreveOutput(escreveOutput), .entrada(entrada),
    .haltOut(haltOut), .leds(leds),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );

  assign disp = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues one OUT request from a negedge; returns stall length and display seen during DONE.
  task automatic run_out(input logic [31:0] v, input bit tog, output int hc, output logic [55:0] pre);
    hc = 0;
    entrada = v;
    escreveOutput = 1'b1;
    #1;
    while (haltOut === 1'b1 && hc < 100) begin
      hc++;
      @(negedge clock);
      if (tog) entrada = ~entrada;
      #1;
    end
    pre = disp;
    escreveOutput = 1'b0;
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    escreveOutput = 1'b0;
    entrada = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (haltOut !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b want=0", haltOut); end
    checks++;
    if (leds !== 18'h0) begin failures++; $display("FAIL reset_leds got=%h want=0", leds); end
    checks++;
    if (disp !== {8{BL}}) begin failures++; $display("FAIL reset_hex got=%h want=%h", disp, {8{BL}}); end
    $display("reset: halt=%b leds=%h hex=%h", haltOut, leds, disp);
  endtask

  task automatic test_1234;
    int hc; logic [55:0] pre;
    run_out(32'd1234, 1'b0, hc, pre);
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL n1234_halt_cycles got=%0d want=33", hc); end
    checks++;
    if (pre !== {8{BL}}) begin failures++; $display("FAIL n1234_early_update got=%h want=%h", pre, {8{BL}}); end
    checks++;
    if (disp !== {BL, BL, BL, BL, D1, D2, D3, D4}) begin
      failures++; $display("FAIL n1234_hex got=%h want=%h", disp, {BL, BL, BL, BL, D1, D2, D3, D4});
    end
    checks++;
    if (leds !== 18'd1234) begin failures++; $display("FAIL n1234_leds got=%h want=%h", leds, 18'd1234); end
    $display("out 1234: halt_cycles=%0d hex=%h leds=%h", hc, disp, leds);
  endtask

  task automatic test_zero;
    int hc; logic [55:0] pre;
    run_out(32'd0, 1'b0, hc, pre);
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL zero_halt_cycles got=%0d want=33", hc); end
    checks++;
    if (disp !== {BL, BL, BL, BL, BL, BL, BL, D0}) begin
      failures++; $display("FAIL zero_hex got=%h want=%h", disp, {BL, BL, BL, BL, BL, BL, BL, D0});
    end
    $display("out 0: halt_cycles=%0d hex=%h", hc, disp);
  endtask

  task automatic test_nines;
    int hc; logic [55:0] pre;
    run_out(32'd99_999_999, 1'b0, hc, pre);
`ifdef OUT_DISPLAY_SIGNED_EN
    checks++;
    if (hc !== 1) begin failures++; $display("FAIL nines_halt_cycles got=%0d want=1", hc); end
    checks++;
    if (disp !== {8{DA}}) begin failures++; $display("FAIL nines_hex got=%h want=%h", disp, {8{DA}}); end
`else
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL nines_halt_cycles got=%0d want=33", hc); end
    checks++;
    if (disp !== {8{D9}}) begin failures++; $display("FAIL nines_hex got=%h want=%h", disp, {8{D9}}); end
`endif
    $display("out 99999999: halt_cycles=%0d hex=%h", hc, disp);
  endtask

  task automatic test_overflow;
    int hc; logic [55:0] pre;
    run_out(32'd100_000_000, 1'b0, hc, pre);
    checks++;
    if (hc !== 1) begin failures++; $display("FAIL ovf_halt_cycles got=%0d want=1", hc); end
    checks++;
    if (disp !== {8{DA}}) begin failures++; $display("FAIL ovf_hex got=%h want=%h", disp, {8{DA}}); end
    checks++;
    if (leds !== 18'h1E100) begin failures++; $display("FAIL ovf_leds got=%h want=1e100", leds); end
    $display("out 100000000: halt_cycles=%0d hex=%h leds=%h", hc, disp, leds);
  endtask

  task automatic test_leds_max;
    int hc; logic [55:0] pre;
    run_out(32'h0003_FFFF, 1'b0, hc, pre);
    checks++;
    if (leds !== 18'h3FFFF) begin failures++; $display("FAIL leds_max got=%h want=3ffff", leds); end
    checks++;
    if (disp !== {BL, BL, D2, D6, D2, D1, D4, D3}) begin
      failures++; $display("FAIL leds_max_hex got=%h want=%h", disp, {BL, BL, D2, D6, D2, D1, D4, D3});
    end
    $display("out 0x3ffff: halt_cycles=%0d hex=%h leds=%h", hc, disp, leds);
  endtask

  task automatic test_back_to_back;
    int hc; logic [55:0] pre;
    run_out(32'd56, 1'b1, hc, pre);
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL b2b_first_halt got=%0d want=33", hc); end
    checks++;
    if (disp !== {BL, BL, BL, BL, BL, BL, D5, D6}) begin
      failures++; $display("FAIL b2b_first_hex got=%h want=%h", disp, {BL, BL, BL, BL, BL, BL, D5, D6});
    end
    checks++;
    if (leds !== 18'd56) begin failures++; $display("FAIL b2b_first_leds got=%h want=%h", leds, 18'd56); end
    $display("out 56 (entrada toggled): halt_cycles=%0d hex=%h leds=%h", hc, disp, leds);
    run_out(32'd7, 1'b1, hc, pre);
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL b2b_second_halt got=%0d want=33", hc); end
    checks++;
    if (disp !== {BL, BL, BL, BL, BL, BL, BL, D7}) begin
      failures++; $display("FAIL b2b_second_hex got=%h want=%h", disp, {BL, BL, BL, BL, BL, BL, BL, D7});
    end
    $display("out 7 (entrada toggled): halt_cycles=%0d hex=%h", hc, disp);
  endtask

  task automatic test_reset_mid;
    int hc; logic [55:0] pre;
    entrada = 32'd1234;
    escreveOutput = 1'b1;
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (haltOut !== 1'b0) begin failures++; $display("FAIL midreset_halt got=%b want=0", haltOut); end
    checks++;
    if (disp !== {8{BL}}) begin failures++; $display("FAIL midreset_hex got=%h want=%h", disp, {8{BL}}); end
    checks++;
    if (leds !== 18'h0) begin failures++; $display("FAIL midreset_leds got=%h want=0", leds); end
    $display("reset mid-convert: halt=%b hex=%h leds=%h", haltOut, disp, leds);
    escreveOutput = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_out(32'd5, 1'b0, hc, pre);
    checks++;
    if (hc !== 33) begin failures++; $display("FAIL midreset_after_halt got=%0d want=33", hc); end
    checks++;
    if (disp !== {BL, BL, BL, BL, BL, BL, BL, D5}) begin
      failures++; $display("FAIL midreset_after_hex got=%h want=%h", disp, {BL, BL, BL, BL, BL, BL, BL, D5});
    end
    $display("out 5 after reset: halt_cycles=%0d hex=%h", hc, disp);
  endtask

`ifdef OUT_DISPLAY_SIGNED_EN
  task automatic test_signed;
    int hc; logic [55:0] pre;
    run_out(-32'sd42, 1'b0, hc, pre);
    checks++;
    if (disp !== {BL, BL, BL, BL, BL, DA, D4, D2}) begin
      failures++; $display("FAIL signed_m42 got=%h want=%h", disp, {BL, BL, BL, BL, BL, DA, D4, D2});
    end
    checks++;
    if (leds !== 18'h3FFD6) begin failures++; $display("FAIL signed_m42_leds got=%h want=3ffd6", leds); end
    $display("out -42: halt_cycles=%0d hex=%h leds=%h", hc, disp, leds);
    run_out(32'h8000_0000, 1'b0, hc, pre);
    checks++;
    if (disp !== {8{DA}} || hc !== 1) begin
      failures++; $display("FAIL signed_minint got=%h/%0d want=%h/1", disp, hc, {8{DA}});
    end
    $display("out 0x80000000: halt_cycles=%0d hex=%h", hc, disp);
    run_out(32'd9_999_999, 1'b0, hc, pre);
    checks++;
    if (disp !== {BL, D9, D9, D9, D9, D9, D9, D9}) begin
      failures++; $display("FAIL signed_limit got=%h want=%h", disp, {BL, D9, D9, D9, D9, D9, D9, D9});
    end
    $display("out 9999999: halt_cycles=%0d hex=%h", hc, disp);
    run_out(32'd10_000_000, 1'b0, hc, pre);
    checks++;
    if (disp !== {8{DA}} || hc !== 1) begin
      failures++; $display("FAIL signed_over got=%h/%0d want=%h/1", disp, hc, {8{DA}});
    end
    $display("out 10000000: halt_cycles=%0d hex=%h", hc, disp);
  endtask
`endif

  initial begin
    test_reset();
    test_1234();
    test_zero();
    test_nines();
    test_overflow();
    test_leds_max();
    test_back_to_back();
    test_reset_mid();
`ifdef OUT_DISPLAY_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
